// File: rtl/sram_req_arbiter.sv
// Two-client arbiter for a single SRAM controller channel. VGA reads normally win, and the decoder is
// forced through after a bounded wait. Read data returns in order to its requester via a source-tag FIFO.
module sram_req_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int TAGQ_DEPTH = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              vga_req_valid,
  input  logic [ADDR_W-1:0] vga_req_addr,
  output logic              vga_req_ready,
  output logic              vga_resp_valid,
  output logic [DATA_W-1:0] vga_resp_data,
  input  logic              dec_req_valid,
  input  logic              dec_req_we,
  input  logic [ADDR_W-1:0] dec_req_addr,
  input  logic [DATA_W-1:0] dec_req_data,
  input  logic [3:0]        dec_req_be,
  output logic              dec_req_ready,
  output logic              dec_resp_valid,
  output logic [DATA_W-1:0] dec_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [3:0]        mem_req_be,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err_resp_unexp
);

  localparam int PTR_W = $clog2(TAGQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAGQ_DEPTH);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_DEC} gnt_e;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        be;
  } req_t;

  req_t              stage_q, stage_d;
  logic              tag_mem_q [TAGQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              vga_rv_q, dec_rv_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              err_q;

  gnt_e gnt;
  logic stage_free, rd_ok, vga_elig, dec_elig, force_dec;
  logic tag_push, tag_pop, tag_empty;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    gnt        = GNT_NONE;
    stage_free = !stage_q.valid | mem_req_ready;
    rd_ok      = tag_cnt_q < CNT_FULL;
    vga_elig   = vga_req_valid & rd_ok;
    dec_elig   = dec_req_valid & (dec_req_we | rd_ok);
    force_dec  = (starve_q == SC_MAX) & dec_elig;
    if (stage_free) begin
      if (force_dec)     gnt = GNT_DEC;
      else if (vga_elig) gnt = GNT_VGA;
      else if (dec_elig) gnt = GNT_DEC;
    end
  end

  assign vga_req_ready = (gnt == GNT_VGA);
  assign dec_req_ready = (gnt == GNT_DEC);

  // The tag count is checked before the same-cycle pop, so a full FIFO blocks reads for one extra cycle.
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_pop   = mem_resp_valid & !tag_empty;
  assign tag_push  = vga_req_ready | (dec_req_ready & !dec_req_we);

  always_comb begin
    stage_d   = stage_q;
    tag_cnt_d = tag_cnt_q;
    starve_d  = starve_q;

    if (gnt == GNT_VGA) begin
      stage_d = '{valid: 1'b1, we: 1'b0, addr: vga_req_addr, data: '0, be: 4'hF};
    end else if (gnt == GNT_DEC) begin
      stage_d = '{valid: 1'b1, we: dec_req_we, addr: dec_req_addr, data: dec_req_data,
                  be: (dec_req_we ? dec_req_be : 4'hF)};
    end else if (stage_free) begin
      stage_d.valid = 1'b0;
    end

    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase

    if (!dec_req_valid || dec_req_ready) starve_d = '0;
    else if (starve_q != SC_MAX)         starve_d = starve_q + SC_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
      starve_q    <= '0;
      vga_rv_q    <= 1'b0;
      dec_rv_q    <= 1'b0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      tag_cnt_q <= tag_cnt_d;
      starve_q  <= starve_d;
      if (tag_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      vga_rv_q <= tag_pop & !tag_mem_q[rd_ptr_q];
      dec_rv_q <= tag_pop &  tag_mem_q[rd_ptr_q];
      if (tag_pop) resp_data_q <= mem_resp_data;
      err_q <= err_q | (mem_resp_valid & tag_empty);
    end
  end

  // NOTE: tag storage is deliberately not reset; the count and pointers decide which entries are live.
  always_ff @(posedge CLK) begin
    if (tag_push) tag_mem_q[wr_ptr_q] <= (gnt == GNT_DEC);
  end

  assign mem_req_valid  = stage_q.valid;
  assign mem_req_we     = stage_q.we;
  assign mem_req_addr   = stage_q.addr;
  assign mem_req_data   = stage_q.data;
  assign mem_req_be     = stage_q.be;
  assign vga_resp_valid = vga_rv_q;
  assign dec_resp_valid = dec_rv_q;
  assign vga_resp_data  = resp_data_q;
  assign dec_resp_data  = resp_data_q;
  assign err_resp_unexp = err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_sram_req_arbiter;

  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 32;
  localparam int TAGQ_DEPTH = 4;
  localparam int STARVE_MAX = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              vga_req_valid, vga_req_ready, vga_resp_valid;
  logic [ADDR_W-1:0] vga_req_addr;
  logic [DATA_W-1:0] vga_resp_data;
  logic              dec_req_valid, dec_req_we, dec_req_ready, dec_resp_valid;
  logic [ADDR_W-1:0] dec_req_addr;
  logic [DATA_W-1:0] dec_req_data, dec_resp_data;
  logic [3:0]        dec_req_be;
  logic              mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data, mem_resp_data;
  logic [3:0]        mem_req_be;
  logic              err_resp_unexp;

  sram_req_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAGQ_DEPTH(TAGQ_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .vga_req_valid(vga_req_valid), .vga_req_addr(vga_req_addr), .vga_req_ready(vga_req_ready),
    .vga_resp_valid(vga_resp_valid), .vga_resp_data(vga_resp_data),
    .dec_req_valid(dec_req_valid), .dec_req_we(dec_req_we), .dec_req_addr(dec_req_addr),
    .dec_req_data(dec_req_data), .dec_req_be(dec_req_be), .dec_req_ready(dec_req_ready),
    .dec_resp_valid(dec_resp_valid), .dec_resp_data(dec_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .err_resp_unexp(err_resp_unexp)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit                v;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        be;
  } req_t;

  // Behavioural model: pending request, queue of outstanding read owners, wait counter, response slot.
  req_t              m_stage;
  bit                m_tagq[$];
  int                m_starve;
  bit                m_rv, m_rd, m_err;
  logic [DATA_W-1:0] m_rdata;
  // Controller stand-in: read data owed for accepted reads, in order.
  logic [DATA_W-1:0] env_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit obs_vga_rdy, obs_dec_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] hash(input logic [ADDR_W-1:0] a);
    return {a[13:0], a} ^ 32'h5A3C_0F96;
  endfunction

  function automatic void model_reset();
    m_stage = '{v: 0, we: 0, addr: '0, data: '0, be: '0};
    m_tagq.delete();
    m_starve = 0;
    m_rv = 0; m_rd = 0; m_err = 0;
    m_rdata = '0;
    env_q.delete();
  endfunction

  // Entered just after a rising edge with inputs already driven; compares, advances the model,
  // and returns just after the next rising edge.
  task automatic cycle();
    bit sf, rd_ok, ve, de, gv, gd, t;
    #2;
    check("vga_resp_valid", vga_resp_valid, m_rv);
    check("dec_resp_valid", dec_resp_valid, m_rd);
    if (m_rv) check("vga_resp_data", vga_resp_data, m_rdata);
    if (m_rd) check("dec_resp_data", dec_resp_data, m_rdata);
    check("mem_req_valid", mem_req_valid, m_stage.v);
    if (m_stage.v) begin
      check("mem_req_we", mem_req_we, m_stage.we);
      check("mem_req_addr", mem_req_addr, m_stage.addr);
      check("mem_req_be", mem_req_be, m_stage.be);
      if (m_stage.we) check("mem_req_data", mem_req_data, m_stage.data);
    end
    check("err_resp_unexp", err_resp_unexp, m_err);

    sf    = !m_stage.v || mem_req_ready;
    rd_ok = m_tagq.size() < TAGQ_DEPTH;
    ve    = vga_req_valid && rd_ok;
    de    = dec_req_valid && (dec_req_we || rd_ok);
    gv = 0; gd = 0;
    if (sf) begin
      if (m_starve == STARVE_MAX && de) gd = 1;
      else if (ve)                      gv = 1;
      else if (de)                      gd = 1;
    end
    check("vga_req_ready", vga_req_ready, gv);
    check("dec_req_ready", dec_req_ready, gd);
    obs_vga_rdy = vga_req_ready;
    obs_dec_rdy = dec_req_ready;

    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      if (m_stage.v && mem_req_ready && !m_stage.we) env_q.push_back(hash(m_stage.addr));
      m_rv = 0; m_rd = 0;
      if (mem_resp_valid) begin
        if (m_tagq.size() > 0) begin
          t = m_tagq.pop_front();
          m_rv = !t; m_rd = t;
          m_rdata = mem_resp_data;
        end else begin
          m_err = 1;
        end
      end
      if (gv) m_tagq.push_back(0);
      if (gd && !dec_req_we) m_tagq.push_back(1);
      if (gv)
        m_stage = '{v: 1, we: 0, addr: vga_req_addr, data: '0, be: 4'hF};
      else if (gd)
        m_stage = '{v: 1, we: dec_req_we, addr: dec_req_addr, data: dec_req_data,
                    be: (dec_req_we ? dec_req_be : 4'hF)};
      else if (sf)
        m_stage.v = 0;
      if (!dec_req_valid || gd)       m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    vga_req_valid = 0; vga_req_addr = '0;
    dec_req_valid = 0; dec_req_we = 0; dec_req_addr = '0; dec_req_data = '0; dec_req_be = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    cycle();
    RST = 0;
  endtask

  // Controller answers with the data owed for the oldest accepted read, if any.
  task automatic env_resp(input int pct);
    mem_resp_valid = 0;
    mem_resp_data  = $urandom;
    if (env_q.size() > 0 && $urandom_range(99) < pct) begin
      mem_resp_valid = 1;
      mem_resp_data  = env_q.pop_front();
    end
  endtask

  task automatic rand_inputs(input int pv, input int pd, input int pr, input int presp);
    vga_req_valid = $urandom_range(99) < pv;
    vga_req_addr  = ADDR_W'($urandom);
    dec_req_valid = $urandom_range(99) < pd;
    dec_req_we    = $urandom_range(1);
    dec_req_addr  = ADDR_W'($urandom);
    dec_req_data  = $urandom;
    dec_req_be    = 4'($urandom);
    mem_req_ready = $urandom_range(99) < pr;
    env_resp(presp);
  endtask

  initial begin
    RST = 1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    model_reset();

    // Reset state
    do_reset();
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst mem_req_we", mem_req_we, 0);
    check("rst mem_req_addr", mem_req_addr, 0);
    check("rst mem_req_data", mem_req_data, 0);
    check("rst mem_req_be", mem_req_be, 0);
    check("rst err", err_resp_unexp, 0);

    // Back-to-back VGA reads, in-order data return
    mem_req_ready = 1;
    vga_req_valid = 1; vga_req_addr = 18'h00010;
    cycle();
    check("t1 rdy0", obs_vga_rdy, 1);
    check("t1 addr0", mem_req_addr, 18'h00010);
    vga_req_addr = 18'h00011;
    cycle();
    check("t1 rdy1", obs_vga_rdy, 1);
    check("t1 addr1", mem_req_addr, 18'h00011);
    vga_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 32'hD000_0010;
    cycle();
    check("t1 resp0 v", vga_resp_valid, 1);
    check("t1 resp0 d", vga_resp_data, 32'hD000_0010);
    mem_resp_data = 32'hD000_0011;
    cycle();
    check("t1 resp1 v", vga_resp_valid, 1);
    check("t1 resp1 d", vga_resp_data, 32'hD000_0011);
    check("t1 no dec", dec_resp_valid, 0);
    mem_resp_valid = 0;
    cycle();

    // Starvation bound: decoder write wins on the 17th contended cycle
    do_reset();
    env_q.delete();
    mem_req_ready = 1;
    vga_req_valid = 1;
    dec_req_valid = 1; dec_req_we = 1; dec_req_addr = 18'h3FFFF;
    dec_req_data = 32'hCAFE_F00D; dec_req_be = 4'h5;
    for (int i = 0; i < 16; i++) begin
      vga_req_addr = ADDR_W'(18'h00200 + i);
      env_resp(100);
      cycle();
      check("t2 vga wins", obs_vga_rdy, 1);
      check("t2 dec waits", obs_dec_rdy, 0);
    end
    env_resp(100);
    cycle();
    check("t2 dec forced", obs_dec_rdy, 1);
    check("t2 vga held", obs_vga_rdy, 0);
    check("t2 we", mem_req_we, 1);
    check("t2 be", mem_req_be, 4'h5);
    check("t2 addr", mem_req_addr, 18'h3FFFF);
    env_resp(100);
    cycle();
    check("t2 counter cleared", obs_vga_rdy, 1);
    vga_req_valid = 0; dec_req_valid = 0;
    for (int i = 0; i < 6; i++) begin
      env_resp(100);
      cycle();
    end

    // Read capacity: fifth read blocked, write still accepted, read granted after a pop
    do_reset();
    mem_req_ready = 1;
    vga_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      vga_req_addr = ADDR_W'(18'h00100 + i);
      cycle();
      check("t3 read slot", obs_vga_rdy, 1);
    end
    vga_req_addr = 18'h00104;
    dec_req_valid = 1; dec_req_we = 1; dec_req_addr = 18'h00400; dec_req_be = 4'hF;
    cycle();
    check("t3 read full", obs_vga_rdy, 0);
    check("t3 write ok", obs_dec_rdy, 1);
    dec_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 32'h1111_0000;
    cycle();
    check("t3 pop cycle blocked", obs_vga_rdy, 0);
    mem_resp_valid = 0;
    cycle();
    check("t3 after pop", obs_vga_rdy, 1);
    vga_req_valid = 0;
    cycle();

    // Interleaved owners get their own data in order
    do_reset();
    mem_req_ready = 1;
    vga_req_valid = 1; vga_req_addr = 18'h00020;
    cycle();
    vga_req_valid = 0;
    dec_req_valid = 1; dec_req_we = 0; dec_req_addr = 18'h00021;
    cycle();
    check("t4 dec read", obs_dec_rdy, 1);
    dec_req_valid = 0;
    vga_req_valid = 1; vga_req_addr = 18'h00022;
    cycle();
    vga_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 32'hA;
    cycle();
    check("t4 A vga", vga_resp_valid, 1);
    check("t4 A data", vga_resp_data, 32'hA);
    mem_resp_data = 32'hB;
    cycle();
    check("t4 B dec", dec_resp_valid, 1);
    check("t4 B data", dec_resp_data, 32'hB);
    check("t4 B not vga", vga_resp_valid, 0);
    mem_resp_data = 32'hC;
    cycle();
    check("t4 C vga", vga_resp_valid, 1);
    check("t4 C data", vga_resp_data, 32'hC);
    mem_resp_valid = 0;
    cycle();

    // Back-pressure holds the stage
    do_reset();
    vga_req_valid = 1; vga_req_addr = 18'h00030;
    cycle();
    vga_req_addr = 18'h00031;
    dec_req_valid = 1; dec_req_we = 1; dec_req_addr = 18'h00500; dec_req_be = 4'h3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5 vga stalled", obs_vga_rdy, 0);
      check("t5 dec stalled", obs_dec_rdy, 0);
      check("t5 addr stable", mem_req_addr, 18'h00030);
    end
    mem_req_ready = 1;
    cycle();
    check("t5 release", obs_vga_rdy, 1);
    check("t5 next addr", mem_req_addr, 18'h00031);
    vga_req_valid = 0; dec_req_valid = 0;
    cycle();

    // Unexpected response is sticky until reset, including after a reset drops in-flight tags
    do_reset();
    mem_resp_valid = 1; mem_resp_data = 32'hDEAD;
    cycle();
    mem_resp_valid = 0;
    check("t6 err set", err_resp_unexp, 1);
    repeat (3) cycle();
    check("t6 err sticky", err_resp_unexp, 1);
    do_reset();
    check("t6 err cleared", err_resp_unexp, 0);
    mem_req_ready = 1;
    vga_req_valid = 1; vga_req_addr = 18'h00040;
    cycle();
    vga_req_valid = 0;
    do_reset();
    mem_resp_valid = 1;
    cycle();
    mem_resp_valid = 0;
    check("t6 dropped tag err", err_resp_unexp, 1);
    check("t6 no resp", vga_resp_valid, 0);

    // Randomized traffic under several load mixes
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 1500; i++) begin
        case (p)
          0:       rand_inputs(50, 50, 80, 70);
          1:       rand_inputs(95, 90, 100, 90);
          2:       rand_inputs(70, 70, 40, 30);
          default: rand_inputs(90, 80, 90, 10);
        endcase
        cycle();
      end
    end
    idle_inputs();
    mem_req_ready = 1;
    for (int i = 0; i < 20; i++) begin
      env_resp(100);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
